// File: rtl/key_reg_bank_if.sv
// Bundle of the per-channel switch inputs, shared controls and the registered
// channel outputs of key_reg_bank.
interface key_reg_bank_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] d;
  logic [1:0]       mode;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] stable;

  modport master (output d, mode, clr, input  q, rise, stable);
  modport slave  (input  d, mode, clr, output q, rise, stable);
endinterface

// File: rtl/key_reg_bank.sv
// WIDTH independent switch channels: synchronise, debounce, detect accepted
// rising edges and drive a registered output in follow/toggle/sticky/hold mode.
module key_reg_bank #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          reset,
  key_reg_bank_if.slave bus
);
  logic [WIDTH-1:0] q_w, rise_w, stable_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    key_reg_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .d_i      (bus.d[i]),
      .mode_i   (bus.mode),
      .clr_i    (bus.clr),
      .q_o      (q_w[i]),
      .rise_o   (rise_w[i]),
      .stable_o (stable_w[i])
    );
  end

  assign bus.q      = q_w;
  assign bus.rise   = rise_w;
  assign bus.stable = stable_w;
endmodule

module key_reg_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       q_o,
  output logic       rise_o,
  output logic       stable_o
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_STICKY = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  logic          stable_q, stable_d, rise_q, rise_d, q_q, q_d;
  logic          accept;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = d_i;
    sync2_d  = sync1_q;
    cnt_d    = '0;
    stable_d = stable_q;
    accept   = 1'b0;
    // Any sample that matches the current level restarts the stability window.
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        accept   = 1'b1;
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = accept & sync2_q;

    q_d = q_q;
    case (mode_e'(mode_i))
      MODE_FOLLOW: q_d = stable_q;
      MODE_TOGGLE: q_d = q_q ^ rise_q;
      MODE_STICKY: q_d = q_q | rise_q;
      default:     q_d = q_q;
    endcase
    if (clr_i) q_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      q_q      <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      q_q      <= q_d;
    end
  end

  assign q_o      = q_q;
  assign rise_o   = rise_q;
  assign stable_o = stable_q;
endmodule

// File: tb/tb_key_reg_bank.sv
// Directed and randomized checks of key_reg_bank against a sample-history
// reference model (acceptance = DEBOUNCE_CYCLES consecutive differing samples).
module tb_key_reg_bank;
  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;

  key_reg_bank_if #(.WIDTH(W)) bus ();

  key_reg_bank #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: every d sample seen at an edge, preceded by the two zero
  // samples the synchroniser holds after reset.
  logic [W-1:0] hist[$];
  int           edge_n;
  int           last_acc[W];
  logic [W-1:0] m_q, m_rise, m_stable;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    edge_n = 0;
    for (int i = 0; i < W; i++) last_acc[i] = -1;
    m_q      = '0;
    m_rise   = '0;
    m_stable = '0;
  endtask

  // One clock edge: predict, advance the DUT, compare all outputs.
  task automatic step();
    logic [W-1:0] nr, ns, nq;
    int  sz;
    bit  acc;
    sz = hist.size();
    nr = '0;
    ns = m_stable;
    for (int i = 0; i < W; i++) begin
      acc = (edge_n - D + 1 > last_acc[i]);
      for (int k = 0; k < D; k++)
        if (sz - 2 - k < 0 || hist[sz-2-k][i] == m_stable[i]) acc = 0;
      if (acc) begin
        ns[i]       = ~m_stable[i];
        nr[i]       = ~m_stable[i];
        last_acc[i] = edge_n;
      end
    end
    case (bus.mode)
      2'b00:   nq = m_stable;
      2'b01:   nq = m_q ^ m_rise;
      2'b10:   nq = m_q | m_rise;
      default: nq = m_q;
    endcase
    if (bus.clr) nq = '0;
    hist.push_back(bus.d);
    edge_n++;
    m_q      = nq;
    m_rise   = nr;
    m_stable = ns;
    @(posedge clk);
    #1;
    chk("q", bus.q, m_q);
    chk("rise", bus.rise, m_rise);
    chk("stable", bus.stable, m_stable);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Asynchronous reset pulse asserted between edges, released on a falling edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_q", bus.q, '0);
    chk("rst_rise", bus.rise, '0);
    chk("rst_stable", bus.stable, '0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    bus.d    = 4'hF;
    bus.mode = 2'b01;
    bus.clr  = 1'b0;
    model_reset();

    // d high throughout reset: nothing moves until release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_q", bus.q, 4'h0);
    chk("rst_hold_rise", bus.rise, 4'h0);
    chk("rst_hold_stable", bus.stable, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    run(5);
    chk("rel_stable_e4", bus.stable, 4'h0);
    step();
    chk("rel_stable_e5", bus.stable, 4'hF);
    chk("rel_rise_e5", bus.rise, 4'hF);
    step();
    chk("rel_q_e6", bus.q, 4'hF);

    // Follow mode and latency of a falling input.
    bus.mode = 2'b00;
    run(3);
    bus.d = 4'hE;
    run(6);
    chk("fol_stable_e5", bus.stable, 4'hE);
    chk("fol_q_e5", bus.q, 4'hF);
    step();
    chk("fol_q_e6", bus.q, 4'hE);

    // Glitch of 3 cycles discarded, 4 cycles accepted.
    bus.d = 4'h0;
    run(10);
    bus.d = 4'h2;
    run(3);
    bus.d = 4'h0;
    run(10);
    chk("glitch3_stable", bus.stable, 4'h0);
    chk("glitch3_q", bus.q, 4'h0);
    bus.d = 4'h2;
    run(4);
    bus.d = 4'h0;
    run(2);
    chk("glitch4_stable", bus.stable, 4'h2);
    run(10);

    // Toggle: three presses on channel 2.
    bus.mode = 2'b01;
    bus.clr  = 1'b1;
    step();
    bus.clr  = 1'b0;
    for (int p = 0; p < 3; p++) begin
      logic [W-1:0] exp_t;
      exp_t = (p % 2 == 0) ? 4'h4 : 4'h0;
      bus.d = 4'h4;
      run(8);
      chk("toggle_q", bus.q, exp_t);
      bus.d = 4'h0;
      run(8);
    end

    // Sticky, clr colliding with a rise pulse, then hold.
    bus.mode = 2'b10;
    bus.clr  = 1'b1;
    step();
    bus.clr  = 1'b0;
    bus.d    = 4'h8;
    run(8);
    chk("sticky_set", bus.q, 4'h8);
    bus.d = 4'h0;
    run(10);
    chk("sticky_keep", bus.q, 4'h8);
    bus.d = 4'h1;
    run(6);
    chk("clr_rise_pulse", bus.rise, 4'h1);
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    chk("clr_over_rise", bus.q, 4'h0);
    bus.d = 4'h9;
    run(8);
    chk("sticky_ch3", bus.q, 4'h8);
    bus.mode = 2'b11;
    bus.d    = 4'h2;
    run(12);
    chk("hold_frozen", bus.q, 4'h8);

    // Reset in the middle of a debounce window.
    bus.mode = 2'b01;
    bus.d    = 4'h0;
    run(12);
    bus.d = 4'hF;
    run(4);
    pulse_reset();
    run(5);
    chk("mid_rst_e4", bus.stable, 4'h0);
    step();
    chk("mid_rst_e5", bus.stable, 4'hF);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++)
        if ($urandom_range(0, 19) == 0) bus.d[i] = ~bus.d[i];
      if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/key_reg_bank.md
# key_reg_bank

Parametrised multi-channel registered input bank: the next generation of the single D flip-flop that drove one LED from one switch. Each of WIDTH channels takes an asynchronous switch/key input, synchronises and debounces it, detects rising edges, and drives a registered output under one of four modes: follow, toggle, sticky latch or hold. It sits between the board's S-switch/key pins and the LED or control logic, clocked from the 50 MHz board oscillator.

## Interface
- WIDTH, 4, number of independent channels (≥1)
- DEBOUNCE_CYCLES, 1000000, cycles an input must stay stable before acceptance (20 ms at 50 MHz; ≥1)
- clk  input  1  system clock, 50 MHz board oscillator, all flops on rising edge
- reset  input  1  asynchronous, active-low reset; clears every flop in the block
- d  input  WIDTH  raw asynchronous channel inputs (switches/keys)
- mode  input  2  output mode, shared by all channels: 00 follow, 01 toggle, 10 sticky latch, 11 hold
- clr  input  1  synchronous clear of q, active high
- q  output  WIDTH  registered channel outputs (LEDs)
- rise  output  WIDTH  one-cycle pulse per channel on accepted 0→1 transition
- stable  output  WIDTH  debounced level per channel

## Operation
- Per channel: 2-flop synchroniser (sync1, sync2) → debounce counter + stable register → rise detector → output register. Channels are fully independent; mode and clr are common.
- Counter width is ceil(log2(DEBOUNCE_CYCLES+1)) bits, computed internally; no overflow possible.
- Debounce, per edge: sync2 == stable → cnt <= 0. sync2 != stable and cnt < DEBOUNCE_CYCLES-1 → cnt <= cnt+1. sync2 != stable and cnt == DEBOUNCE_CYCLES-1 → stable <= sync2, cnt <= 0 ("accept").
- Any return of sync2 to the stable value before acceptance resets cnt to 0; glitches shorter than DEBOUNCE_CYCLES cycles are discarded completely.
- rise[i] <= accept[i] && sync2[i]; registered, high exactly one cycle per accepted rising transition. Falling acceptances produce no pulse.
- Output register, per edge, in priority order:
  - clr = 1 → q <= 0 (overrides rise in the same cycle, in every mode)
  - mode 00 follow → q <= stable
  - mode 01 toggle → q <= q ^ rise
  - mode 10 sticky → q <= q | rise
  - mode 11 hold → q unchanged
- Mode changes take effect on the next edge; switching modes never alters q by itself (entering 00 loads stable on that edge).
- clr does not touch synchroniser, counter, stable or rise.

## Timing
- Reset (reset low, asynchronous): sync1, sync2, cnt, stable, rise, q all 0 immediately; outputs q=0, rise=0, stable=0.
- Reset asserted mid-debounce: count discarded; after release the channel restarts from stable=0.
- d held high through reset release is treated as a new rising transition: accepted, rise pulses, and toggle/sticky modes set q=1.
- Latency, d changes before edge 0 and then holds: sync2 updates at edge 1; stable and rise update at edge DEBOUNCE_CYCLES+1; q updates at edge DEBOUNCE_CYCLES+2 (all modes).
- DEBOUNCE_CYCLES = 1: accept on first mismatch edge; stable at edge 2, q at edge 3.
- rise is one cycle wide; consecutive pulses on one channel are separated by ≥2·DEBOUNCE_CYCLES cycles.
- No combinational path from any input to any output.

## Test plan
- Reset: DEBOUNCE_CYCLES=4, WIDTH=4, drive d=4'hF during reset → q=0, rise=0, stable=0 while reset low; after release, stable=4'hF and rise=4'hF for one cycle at edge 5, and in mode 01 q=4'hF at edge 6.
- Follow/latency: mode 00, d[0] 0→1 before edge 0 → stable[0]=1 at edge 5, q[0]=1 at edge 6, no change earlier; d[0] 1→0 → q[0]=0 six edges later, rise stays 0.
- Glitch rejection: d[1] high for 3 cycles then low → cnt never reaches accept, stable[1], rise[1] and q[1] stay 0; 4+ cycles high → accepted.
- Toggle: mode 01, three clean presses on d[2] → q[2] sequence 1,0,1, one rise pulse per press.
- Sticky + clr: mode 10, press d[3] → q[3]=1 and stays 1 after release; clr=1 in the same cycle as a rise pulse on d[0] → q=0 after that edge; hold mode 11 → q frozen through further presses.
- Reset mid-debounce: reset pulse at cnt=2 → all outputs 0 immediately; with d still high, acceptance occurs DEBOUNCE_CYCLES+1 edges after release.
